// File: rtl/clock_pkg.sv
// Shared encodings and limits for the time-of-day core and its alarm.
package clock_pkg;

    typedef enum logic [2:0] {
        MODE_RUN         = 3'd0,
        MODE_SET_MIN     = 3'd1,
        MODE_SET_HR      = 3'd2,
        MODE_SET_ALM_MIN = 3'd3,
        MODE_SET_ALM_HR  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ALM_IDLE    = 2'd0,
        ALM_RINGING = 2'd1,
        ALM_SNOOZE  = 2'd2
    } alarm_state_e;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_wrap5(input logic [4:0] v, input logic [4:0] max);
        return (v == max) ? 5'd0 : v + 5'd1;
    endfunction

endpackage

// File: rtl/alarm_fsm.sv
// Alarm registers, wake-up compare, IDLE/RINGING/SNOOZE machine and its elapsed-seconds counter.
module alarm_fsm
    import clock_pkg::*;
#(
    parameter int ALARM_LEN_S = 60,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_sec,
    input  logic       i_timeset_stb,
    input  logic [2:0] i_mode,
    input  logic       i_arm,
    input  logic       i_ack,
    input  logic [5:0] i_sec_next,
    input  logic [5:0] i_min_next,
    input  logic [4:0] i_hr_next,
    output logic       o_active
);

    localparam int SNOOZE_S = SNOOZE_MIN * 60;
    localparam int CNT_MAX  = (ALARM_LEN_S > SNOOZE_S) ? ALARM_LEN_S : SNOOZE_S;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(ALARM_LEN_S - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_S - 1);

    alarm_state_e     state;
    logic [CNT_W-1:0] elapsed;
    logic [5:0]       alarm_mm;
    logic [4:0]       alarm_hh;
    logic             run_mode;
    logic             hit;

    assign run_mode = (i_mode == MODE_RUN) || (i_mode > MODE_SET_ALM_HR);
    // Compare against the post-tick time so RINGING lands on the same edge as hh:mm:00.
    assign hit = i_sec && run_mode && (i_sec_next == 6'd0)
                 && (i_min_next == alarm_mm) && (i_hr_next == alarm_hh);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ALM_IDLE;
            elapsed  <= '0;
            alarm_mm <= '0;
            alarm_hh <= '0;
            o_active <= 1'b0;
        end else if (i_en) begin
            if (i_timeset_stb && i_mode == MODE_SET_ALM_MIN) alarm_mm <= inc_wrap6(alarm_mm, MIN_MAX);
            if (i_timeset_stb && i_mode == MODE_SET_ALM_HR)  alarm_hh <= inc_wrap5(alarm_hh, HR_MAX);

            if (!i_arm) begin
                state    <= ALM_IDLE;
                elapsed  <= '0;
                o_active <= 1'b0;
            end else begin
                case (state)
                    ALM_IDLE: if (hit) begin
                        state    <= ALM_RINGING;
                        elapsed  <= '0;
                        o_active <= 1'b1;
                    end
                    ALM_RINGING: if (i_ack) begin
                        state    <= ALM_SNOOZE;
                        elapsed  <= '0;
                        o_active <= 1'b0;
                    end else if (i_sec) begin
                        if (elapsed == RING_LAST) begin
                            state    <= ALM_IDLE;
                            elapsed  <= '0;
                            o_active <= 1'b0;
                        end else begin
                            elapsed <= elapsed + CNT_W'(1);
                        end
                    end
                    ALM_SNOOZE: if (i_sec) begin
                        if (elapsed == SNOOZE_LAST) begin
                            state    <= ALM_RINGING;
                            elapsed  <= '0;
                            o_active <= 1'b1;
                        end else begin
                            elapsed <= elapsed + CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= ALM_IDLE;
                        elapsed  <= '0;
                        o_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/timekeeper_alarm.sv
// Time-of-day core: selectable 1 Hz source, set modes, 12/24 h display, update/shift strobes.
// Define ALARM_EN to build the alarm (alarm_fsm); otherwise o_alarm_active is tied low.
module timekeeper_alarm
    import clock_pkg::*;
#(
    parameter int SRC_COUNT   = 2,
    parameter int SHIFT_DELAY = 4,
    parameter int ALARM_LEN_S = 60,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic [SRC_COUNT-1:0] i_sec_stb,
    input  logic [((SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1)-1:0] i_src_sel,
    input  logic                 i_timeset_stb,
    input  logic [2:0]           i_mode,
    input  logic                 i_12h,
    input  logic                 i_alarm_arm,
    input  logic                 i_alarm_ack,
    output logic [5:0]           o_seconds,
    output logic [5:0]           o_minutes,
    output logic [4:0]           o_hours,
    output logic                 o_pm,
    output logic                 o_alarm_active,
    output logic                 o_colon,
    output logic                 o_update_stb,
    output logic                 o_shift_start_stb
);

    logic [5:0]             seconds, minutes, sec_n, min_n;
    logic [4:0]             hours, hr_n;
    logic                   sec_raw, sec, set_min, set_hr, first_pending;
    logic [SHIFT_DELAY-1:0] dly;

    // Out-of-range selections fall back to source 0.
    always_comb begin
        sec_raw = i_sec_stb[0];
        for (int i = 1; i < SRC_COUNT; i++)
            if (int'(i_src_sel) == i) sec_raw = i_sec_stb[i];
    end

    assign sec     = i_en & sec_raw;
    assign set_min = (i_mode == MODE_SET_MIN);
    assign set_hr  = (i_mode == MODE_SET_HR);

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        sec_n = seconds;
        min_n = minutes;
        hr_n  = hours;
        if (set_min || set_hr) begin
            sec_n = 6'd0;
            if (i_timeset_stb && set_min) min_n = inc_wrap6(minutes, MIN_MAX);
            if (i_timeset_stb && set_hr)  hr_n  = inc_wrap5(hours, HR_MAX);
        end else if (sec) begin
            sec_n = inc_wrap6(seconds, SEC_MAX);
            if (seconds == SEC_MAX) begin
                min_n = inc_wrap6(minutes, MIN_MAX);
                if (minutes == MIN_MAX) hr_n = inc_wrap5(hours, HR_MAX);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seconds       <= '0;
            minutes       <= '0;
            hours         <= '0;
            o_colon       <= 1'b0;
            o_update_stb  <= 1'b0;
            first_pending <= 1'b1;
            dly           <= '0;
        end else if (i_en) begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of order.
            seconds       <= sec_n;
            minutes       <= min_n;
            hours         <= hr_n;
            o_colon       <= o_colon ^ sec;
            o_update_stb  <= first_pending || ({hr_n, min_n, sec_n} != {hours, minutes, seconds});
            first_pending <= 1'b0;
            dly           <= SHIFT_DELAY'({dly, o_update_stb});
        end
    end

    assign o_shift_start_stb = dly[SHIFT_DELAY-1];
    assign o_seconds         = seconds;
    assign o_minutes         = minutes;

    always_comb begin
        o_hours = hours;
        o_pm    = 1'b0;
        if (i_12h) begin
            o_pm = (hours >= 5'd12);
            if (hours == 5'd0)       o_hours = 5'd12;
            else if (hours > 5'd12)  o_hours = hours - 5'd12;
        end
    end

`ifdef ALARM_EN
    alarm_fsm #(
        .ALARM_LEN_S (ALARM_LEN_S),
        .SNOOZE_MIN  (SNOOZE_MIN)
    ) u_alarm (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_en          (i_en),
        .i_sec         (sec),
        .i_timeset_stb (i_timeset_stb),
        .i_mode        (i_mode),
        .i_arm         (i_alarm_arm),
        .i_ack         (i_alarm_ack),
        .i_sec_next    (sec_n),
        .i_min_next    (min_n),
        .i_hr_next     (hr_n),
        .o_active      (o_alarm_active)
    );
`else
    logic unused_alarm;
    assign unused_alarm   = ^{i_alarm_arm, i_alarm_ack};
    assign o_alarm_active = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeper_alarm.sv
// Bench for timekeeper_alarm: randomized strobes checked every cycle against a seconds-of-day model.
`timescale 1ns/1ps
module tb_timekeeper_alarm;

    localparam int SRC_COUNT   = 2;
    localparam int SHIFT_DELAY = 4;
    localparam int ALARM_LEN_S = 60;
    localparam int SNOOZE_MIN  = 5;

    logic       clk = 1'b0;
    logic       reset, en, ts, h12, arm, ack;
    logic [1:0] stb;
    logic [0:0] sel;
    logic [2:0] mode;
    logic [5:0] o_seconds, o_minutes;
    logic [4:0] o_hours;
    logic       o_pm, o_alarm_active, o_colon, o_update_stb, o_shift_start_stb;

    always #5 clk = ~clk;

    timekeeper_alarm #(
        .SRC_COUNT(SRC_COUNT), .SHIFT_DELAY(SHIFT_DELAY),
        .ALARM_LEN_S(ALARM_LEN_S), .SNOOZE_MIN(SNOOZE_MIN)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_sec_stb(stb), .i_src_sel(sel),
        .i_timeset_stb(ts), .i_mode(mode), .i_12h(h12), .i_alarm_arm(arm), .i_alarm_ack(ack),
        .o_seconds(o_seconds), .o_minutes(o_minutes), .o_hours(o_hours), .o_pm(o_pm),
        .o_alarm_active(o_alarm_active), .o_colon(o_colon), .o_update_stb(o_update_stb),
        .o_shift_start_stb(o_shift_start_stb)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time as seconds-of-day, alarm as minutes-of-day, ring/snooze as ticks left.
    int m_tod, m_alm, m_state, m_left;
    bit m_colon, m_first, m_upd, m_shift;
    bit m_hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int old, h, mi, ah, am, src;
        bit s;
        if (reset) begin
            m_tod = 0; m_alm = 0; m_state = 0; m_left = 0;
            m_colon = 0; m_upd = 0; m_shift = 0; m_first = 1;
            m_hist.delete();
            repeat (SHIFT_DELAY) m_hist.push_back(1'b0);
            return;
        end
        if (!en) return;
        src = (int'(sel) < SRC_COUNT) ? int'(sel) : 0;
        s   = stb[src];
        old = m_tod;
        h   = old / 3600;
        mi  = (old / 60) % 60;
        if (mode == 3'd1 || mode == 3'd2) begin
            if (ts && mode == 3'd1) mi = (mi + 1) % 60;
            if (ts && mode == 3'd2) h  = (h + 1) % 24;
            m_tod = h * 3600 + mi * 60;
        end else if (s) begin
            m_tod = (m_tod + 1) % 86400;
        end
`ifdef ALARM_EN
        ah = m_alm / 60;
        am = m_alm % 60;
        if (!arm) m_state = 0;
        else case (m_state)
            0: if (s && (mode == 3'd0 || mode >= 3'd5) && m_tod == m_alm * 60) begin
                m_state = 1; m_left = ALARM_LEN_S;
            end
            1: if (ack) begin
                m_state = 2; m_left = SNOOZE_MIN * 60;
            end else if (s) begin
                m_left--;
                if (m_left == 0) m_state = 0;
            end
            default: if (s) begin
                m_left--;
                if (m_left == 0) begin m_state = 1; m_left = ALARM_LEN_S; end
            end
        endcase
        if (ts && mode == 3'd3) am = (am + 1) % 60;
        if (ts && mode == 3'd4) ah = (ah + 1) % 24;
        m_alm = ah * 60 + am;
`else
        ah = 0; am = 0;
`endif
        m_colon = m_colon ^ s;
        m_upd   = m_first || (m_tod != old);
        m_first = 0;
        m_hist.push_back(m_upd);
        m_shift = m_hist[0];
        void'(m_hist.pop_front());
    endtask

    task automatic compare_all();
        int h, eh;
        h  = m_tod / 3600;
        eh = h12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
        check("seconds", 32'(o_seconds), m_tod % 60);
        check("minutes", 32'(o_minutes), (m_tod / 60) % 60);
        check("hours",   32'(o_hours), eh);
        check("pm",      32'(o_pm), (h12 && h >= 12) ? 1 : 0);
        check("colon",   32'(o_colon), 32'(m_colon));
        check("update",  32'(o_update_stb), 32'(m_upd));
        check("shift",   32'(o_shift_start_stb), 32'(m_shift));
        check("alarm",   32'(o_alarm_active), (m_state == 1) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic tick();
        stb = 2'b01; step(); stb = 2'b00;
    endtask

    int guard, start_tod, tgt_min;

    initial begin
        reset = 1; en = 1; stb = 0; sel = 0; ts = 0; mode = 0; h12 = 0; arm = 0; ack = 0;
        repeat (2) step();
        h12 = 1; step();
        check("reset_hours_12h", 32'(o_hours), 12);
        h12 = 0; reset = 0; step();
        check("first_update", 32'(o_update_stb), 1);

        // RUN with random gaps, enable drops, RUN-like modes and noise on source 1.
        guard = 0;
        while (m_tod != 3661 && guard < 20000) begin
            en   = ($urandom_range(0, 9) != 0);
            stb  = 2'($urandom_range(0, 3));
            ts   = 1'($urandom_range(0, 1));
            mode = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'd0;
            h12  = 1'($urandom_range(0, 1));
            step();
            guard++;
        end
        en = 1; stb = 0; ts = 0; mode = 0; h12 = 0;
        step();
        check("run_hms", {8'd0, 3'd0, o_hours, 2'd0, o_minutes, 2'd0, o_seconds}, {8'd0, 3'd0, 5'd1, 2'd0, 6'd1, 2'd0, 6'd1});

        // Walk to 23:59:59, then one strobe rolls over the day.
        mode = 3'd2; ts = 1;
        for (int i = 0; i < 30 && (m_tod / 3600) != 23; i++) step();
        mode = 3'd1;
        for (int i = 0; i < 70 && ((m_tod / 60) % 60) != 59; i++) step();
        ts = 0; mode = 3'd0;
        for (int i = 0; i < 70 && (m_tod % 60) != 59; i++) tick();
        check("pre_roll_hours", 32'(o_hours), 23);
        h12 = 1; tick();
        check("roll_hours_12h", 32'(o_hours), 12);
        check("roll_pm", 32'(o_pm), 0);
        check("roll_min_sec", {o_minutes, o_seconds}, 0);
        check("roll_update", 32'(o_update_stb), 1);
        h12 = 0;

        // SET_MIN to 57, then three timeset strobes, one with a coincident second.
        tick(); tick();
        mode = 3'd1; ts = 1;
        for (int i = 0; i < 70 && ((m_tod / 60) % 60) != 57; i++) step();
        step();
        stb = 2'b01; step(); stb = 2'b00;
        step();
        ts = 0; step();
        check("set_min_wrap", 32'(o_minutes), 0);
        check("set_min_sec", 32'(o_seconds), 0);
        check("set_min_hours", 32'(o_hours), 0);
        mode = 3'd0;

        // Source 1 selected, strobes on source 0 only: frozen.
        sel = 1; step();
        start_tod = m_tod;
        repeat (10) tick();
        check("sel1_frozen", 32'(o_seconds), start_tod % 60);
        sel = 0; step();
        repeat (5) tick();
        check("sel0_resume", 32'(o_seconds), (start_tod + 5) % 60);

        // Mode 3 with timeset strobes keeps time running as RUN.
        mode = 3'd3;
        start_tod = m_tod;
        for (int i = 0; i < 20; i++) begin
            ts = 1; stb = (i % 2 == 0) ? 2'b01 : 2'b00; step();
        end
        ts = 0; stb = 0; step();
        check("mode3_counts", 32'(o_seconds), ((start_tod + 10) % 86400) % 60);
        check("mode3_no_alarm", 32'(o_alarm_active), 0);
        mode = 3'd0;

        // Fully random inputs, alarm disarmed.
        repeat (400) begin
            en   = ($urandom_range(0, 4) != 0);
            stb  = 2'($urandom_range(0, 3));
            sel  = 1'($urandom_range(0, 1));
            ts   = 1'($urandom_range(0, 1));
            mode = 3'($urandom_range(0, 7));
            h12  = 1'($urandom_range(0, 1));
            step();
        end
        en = 1; stb = 0; sel = 0; ts = 0; mode = 0; h12 = 0;
        step();

`ifdef ALARM_EN
        // Alarm at 07:30, time set to 07:29:00.
        ts = 1;
        mode = 3'd4; for (int i = 0; i < 30 && (m_alm / 60) != 7; i++) step();
        mode = 3'd3; for (int i = 0; i < 70 && (m_alm % 60) != 30; i++) step();
        mode = 3'd2; for (int i = 0; i < 30 && (m_tod / 3600) != 7; i++) step();
        mode = 3'd1; for (int i = 0; i < 70 && ((m_tod / 60) % 60) != 29; i++) step();
        ts = 0; mode = 3'd0; arm = 1;
        for (int i = 0; i < 200 && m_state != 1; i++) tick();
        check("ring_time", {o_hours, o_minutes, o_seconds}, {5'd7, 6'd30, 6'd0});
        check("ring_on", 32'(o_alarm_active), 1);
        ack = 1; step(); ack = 0;
        check("snooze_off", 32'(o_alarm_active), 0);
        repeat (SNOOZE_MIN * 60 - 1) tick();
        check("snooze_hold", 32'(o_alarm_active), 0);
        tick();
        check("snooze_ring", 32'(o_alarm_active), 1);
        arm = 0; step();
        check("disarm_off", 32'(o_alarm_active), 0);

        // Ring until self-clear.
        tgt_min = ((m_tod / 60) % 60 + 2) % 60;
        mode = 3'd3; ts = 1;
        for (int i = 0; i < 70 && (m_alm % 60) != tgt_min; i++) step();
        ts = 0; mode = 3'd0; arm = 1;
        for (int i = 0; i < 200 && m_state != 1; i++) tick();
        check("ring2_on", 32'(o_alarm_active), 1);
        repeat (ALARM_LEN_S - 1) tick();
        check("ring2_hold", 32'(o_alarm_active), 1);
        tick();
        check("ring2_timeout", 32'(o_alarm_active), 0);
        arm = 0;
`endif

        // Reset in the middle of activity.
        stb = 2'b01; reset = 1; h12 = 1; step();
        check("midreset_time", {o_minutes, o_seconds}, 0);
        check("midreset_hours", 32'(o_hours), 12);
        stb = 0; reset = 0; h12 = 0;
        repeat (SHIFT_DELAY + 2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
